// File: rtl/light_pkg.sv
// Shared constants for the light controller: clock rate, button channel map and
// debounce timing defaults.
package light_pkg;

  localparam int CLK_HZ = 100_000_000;

  // Button channel indices, as seen on the light FSM's i_button bus.
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_OFF  = 2;

  localparam int NUM_BTN_DEF = 3;

  // 1 ms of stable input before a level change is accepted.
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 1000;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the light FSM: raw levels in,
// debounced levels and press pulses out.
interface button_conditioner_if
  import light_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF
);

  logic [NUM_BTN-1:0] button_raw;
  logic [NUM_BTN-1:0] button_pulse;
  logic [NUM_BTN-1:0] button_level;

  // master: pin side driving raw levels and consuming the conditioned outputs.
  modport master (
    output button_raw,
    input  button_pulse,
    input  button_level
  );

  // slave: the conditioner itself.
  modport slave (
    input  button_raw,
    output button_pulse,
    output button_level
  );

endinterface

// File: rtl/button_conditioner_debounce_ch.sv
// One button channel: 2-FF synchroniser, counter-based debounce filter and a
// registered one-cycle pulse on each accepted press.
module button_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch can be inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        pulse_d = sync2_q;   // press only; an accepted release stays silent
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others (sync1 -> sync2 shift relies on it).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_level = level_q;
  assign o_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw push buttons into debounced levels and single-cycle press
// pulses for the light FSM; channels are fully independent.
module button_conditioner
  import light_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_BTN-1:0] i_buttonRaw,
  output logic [NUM_BTN-1:0] o_buttonPulse,
  output logic [NUM_BTN-1:0] o_buttonLevel
);

  // Simultaneous pulses are passed through as-is; the FSM resolves priority.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (i_buttonRaw[g]),
      .o_level (o_buttonLevel[g]),
      .o_pulse (o_buttonPulse[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4: every expected
// pulse edge is hand-computed as DEBOUNCE_CYCLES+2 = 6 edges after first sampling.
module tb_button_conditioner;

  localparam int NB = 3;
  localparam int DC = 4;
  localparam int LAT = DC + 2;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  button_conditioner_if #(.NUM_BTN(NB)) btn_if ();

  button_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_buttonRaw   (btn_if.button_raw),
    .o_buttonPulse (btn_if.button_pulse),
    .o_buttonLevel (btn_if.button_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [NB-1:0] exp_p, exp_l;
    reset = 1'b1;
    btn_if.button_raw = 3'b111;
    for (int e = 1; e <= 2; e++) begin
      step();
      n_total++;
      if (btn_if.button_pulse !== 3'b000 || btn_if.button_level !== 3'b000)
        $display("FAIL reset_hold edge %0d: pulse=%b level=%b expected 000/000",
                 e, btn_if.button_pulse, btn_if.button_level);
      else n_pass++;
    end
    reset = 1'b0;
    for (int e = 1; e <= LAT + 3; e++) begin
      step();
      exp_p = (e == LAT) ? 3'b111 : 3'b000;
      exp_l = (e >= LAT) ? 3'b111 : 3'b000;
      n_total++;
      if (btn_if.button_pulse !== exp_p || btn_if.button_level !== exp_l)
        $display("FAIL reset_release edge %0d: pulse=%b level=%b expected %b/%b",
                 e, btn_if.button_pulse, btn_if.button_level, exp_p, exp_l);
      else n_pass++;
    end
    // Release all; no pulse may appear while the release is accepted.
    btn_if.button_raw = 3'b000;
    for (int e = 1; e <= LAT + 3; e++) begin
      step();
      exp_l = (e >= LAT) ? 3'b000 : 3'b111;
      n_total++;
      if (btn_if.button_pulse !== 3'b000 || btn_if.button_level !== exp_l)
        $display("FAIL reset_unpress edge %0d: pulse=%b level=%b expected 000/%b",
                 e, btn_if.button_pulse, btn_if.button_level, exp_l);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    logic [NB-1:0] exp_p, exp_l;
    btn_if.button_raw = 3'b001;
    for (int e = 1; e <= 20; e++) begin
      step();
      exp_p = (e == LAT) ? 3'b001 : 3'b000;
      exp_l = (e >= LAT) ? 3'b001 : 3'b000;
      n_total++;
      if (btn_if.button_pulse !== exp_p || btn_if.button_level !== exp_l)
        $display("FAIL clean_press edge %0d: pulse=%b level=%b expected %b/%b",
                 e, btn_if.button_pulse, btn_if.button_level, exp_p, exp_l);
      else n_pass++;
    end
    btn_if.button_raw = 3'b000;
    for (int e = 1; e <= LAT + 2; e++) begin
      step();
      exp_l = (e >= LAT) ? 3'b000 : 3'b001;
      n_total++;
      if (btn_if.button_pulse !== 3'b000 || btn_if.button_level !== exp_l)
        $display("FAIL clean_release edge %0d: pulse=%b level=%b expected 000/%b",
                 e, btn_if.button_pulse, btn_if.button_level, exp_l);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [NB-1:0] exp_p;
    logic [NB-1:0] pattern [4];
    pattern[0] = 3'b010;
    pattern[1] = 3'b000;
    pattern[2] = 3'b010;
    pattern[3] = 3'b000;
    for (int e = 0; e < 4; e++) begin
      btn_if.button_raw = pattern[e];
      step();
      n_total++;
      if (btn_if.button_pulse !== 3'b000 || btn_if.button_level !== 3'b000)
        $display("FAIL bounce_toggle step %0d: pulse=%b level=%b expected 000/000",
                 e, btn_if.button_pulse, btn_if.button_level);
      else n_pass++;
    end
    btn_if.button_raw = 3'b010;
    for (int e = 1; e <= LAT + 4; e++) begin
      step();
      exp_p = (e == LAT) ? 3'b010 : 3'b000;
      n_total++;
      if (btn_if.button_pulse !== exp_p)
        $display("FAIL bounce_settle edge %0d: pulse=%b expected %b",
                 e, btn_if.button_pulse, exp_p);
      else n_pass++;
    end
    btn_if.button_raw = 3'b000;
    for (int e = 1; e <= LAT + 2; e++) step();
    n_total++;
    if (btn_if.button_level !== 3'b000 || btn_if.button_pulse !== 3'b000)
      $display("FAIL bounce_release: pulse=%b level=%b expected 000/000",
               btn_if.button_pulse, btn_if.button_level);
    else n_pass++;
  endtask

  // Three high cycles are one short of the DC edges needed for acceptance.
  task automatic test_short_glitch();
    btn_if.button_raw = 3'b100;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) btn_if.button_raw = 3'b000;
      step();
      n_total++;
      if (btn_if.button_pulse !== 3'b000 || btn_if.button_level !== 3'b000)
        $display("FAIL short_glitch edge %0d: pulse=%b level=%b expected 000/000",
                 e, btn_if.button_pulse, btn_if.button_level);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] exp_p, exp_l;
    btn_if.button_raw = 3'b011;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_p = (e == LAT) ? 3'b011 : 3'b000;
      exp_l = (e >= LAT) ? 3'b011 : 3'b000;
      n_total++;
      if (btn_if.button_pulse !== exp_p || btn_if.button_level !== exp_l)
        $display("FAIL simul_press edge %0d: pulse=%b level=%b expected %b/%b",
                 e, btn_if.button_pulse, btn_if.button_level, exp_p, exp_l);
      else n_pass++;
    end
    btn_if.button_raw = 3'b000;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_l = (e >= LAT) ? 3'b000 : 3'b011;
      n_total++;
      if (btn_if.button_pulse !== 3'b000 || btn_if.button_level !== exp_l)
        $display("FAIL simul_release edge %0d: pulse=%b level=%b expected 000/%b",
                 e, btn_if.button_pulse, btn_if.button_level, exp_l);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [NB-1:0] exp_p, exp_l;
    // Edges 1-2 synchronise, edges 3-4 bring the counter to 2.
    btn_if.button_raw = 3'b001;
    for (int e = 1; e <= 4; e++) step();
    reset = 1'b1;
    step();
    n_total++;
    if (btn_if.button_pulse !== 3'b000 || btn_if.button_level !== 3'b000)
      $display("FAIL mid_reset_clear: pulse=%b level=%b expected 000/000",
               btn_if.button_pulse, btn_if.button_level);
    else n_pass++;
    reset = 1'b0;
    for (int e = 1; e <= LAT + 3; e++) begin
      step();
      exp_p = (e == LAT) ? 3'b001 : 3'b000;
      exp_l = (e >= LAT) ? 3'b001 : 3'b000;
      n_total++;
      if (btn_if.button_pulse !== exp_p || btn_if.button_level !== exp_l)
        $display("FAIL mid_reset_redebounce edge %0d: pulse=%b level=%b expected %b/%b",
                 e, btn_if.button_pulse, btn_if.button_level, exp_p, exp_l);
      else n_pass++;
    end
    btn_if.button_raw = 3'b000;
    for (int e = 1; e <= LAT + 2; e++) step();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    btn_if.button_raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_glitch();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
